// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the byte-serial memory controller: FSM states,
// lsb_size codes, the IO window constant and a few named constants.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IF_RD = 2'd1,
        LS_RD = 2'd2,
        LS_WR = 2'd3
    } state_t;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    localparam logic [1:0] IO_WINDOW = 2'b11;

    localparam logic        TRUE   = 1'b1;
    localparam logic        FALSE  = 1'b0;
    localparam logic [31:0] NULL32 = 32'd0;
    localparam logic [7:0]  NULL8  = 8'd0;

    // Reserved size code 3 is treated as a full word.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SIZE_B:  size_bytes = 3'd1;
            SIZE_H:  size_bytes = 3'd2;
            SIZE_W:  size_bytes = 3'd4;
            default: size_bytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl_byte_asm.sv
// Little-endian read assembler: inserts one RAM byte per capture into a
// 32-bit word at the lane selected by idx; word_next exposes the merged value.
module mem_ctrl_byte_asm
    import mem_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        en,
    input  logic        clear,
    input  logic        capture,
    input  logic [1:0]  idx,
    input  logic [7:0]  din,
    output logic [31:0] word,
    output logic [31:0] word_next
);

    always_comb begin
        word_next = word;
        if (capture) begin
            word_next[{idx, 3'b000} +: 8] = din;
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            word <= clear ? NULL32 : word_next;
        end
    end

endmodule

// File: rtl/mem_ctrl.sv
// Byte-wide RAM/IO controller arbitrating fetch and load/store traffic.
// Optional IO write back-pressure is enabled with `define MEMCTRL_IO_STALL_EN.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int         ADDR_W = 32,
    parameter logic [1:0] IO_HI  = IO_WINDOW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              jp_wrong,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [31:0]       if_data,
    input  logic              lsb_req,
    input  logic              lsb_we,
    input  logic [ADDR_W-1:0] lsb_addr,
    input  logic [1:0]        lsb_size,
    input  logic [31:0]       lsb_wdata,
    output logic              lsb_done,
    output logic [31:0]       lsb_rdata,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              io_buffer_full
);

    state_t            state_q, state_n;
    logic [2:0]        cnt_q, cnt_n;
    logic [2:0]        nbytes_q, nbytes_n;
    logic [ADDR_W-1:0] base_q, base_n;
    logic [ADDR_W-1:0] mem_a_q, mem_a_n;
    logic [31:0]       wdata_q, wdata_n;
    logic [7:0]        mem_dout_q, mem_dout_n;
    logic              mem_wr_q, mem_wr_n;
    logic              if_done_q, if_done_n;
    logic              lsb_done_q, lsb_done_n;
    logic [31:0]       if_data_q, if_data_n;
    logic [31:0]       lsb_rdata_q, lsb_rdata_n;
    logic              asm_clear, asm_capture;
    logic [31:0]       asm_word, asm_word_next;
    logic              io_stall;
    logic              in_read;

    assign in_read = (state_q == IF_RD) || (state_q == LS_RD);

`ifdef MEMCTRL_IO_STALL_EN
    assign io_stall = (state_q == LS_WR) && (base_q[17:16] == IO_HI) && io_buffer_full;
`else
    logic unused_io;
    assign io_stall  = FALSE;
    assign unused_io = io_buffer_full & (base_q[17:16] == IO_HI);
`endif

    // Lane for the byte arriving now: cycle k captures byte k-2 (mod 4).
    mem_ctrl_byte_asm u_asm (
        .clk       (clk),
        .en        (rdy),
        .clear     (asm_clear),
        .capture   (asm_capture),
        .idx       (cnt_q[1:0] - 2'd2),
        .din       (mem_din),
        .word      (asm_word),
        .word_next (asm_word_next)
    );

    always_comb begin
        state_n     = state_q;
        cnt_n       = cnt_q;
        nbytes_n    = nbytes_q;
        base_n      = base_q;
        mem_a_n     = mem_a_q;
        wdata_n     = wdata_q;
        mem_dout_n  = mem_dout_q;
        mem_wr_n    = FALSE;
        if_done_n   = FALSE;
        lsb_done_n  = FALSE;
        if_data_n   = if_data_q;
        lsb_rdata_n = lsb_rdata_q;
        asm_clear   = FALSE;
        asm_capture = FALSE;

        case (state_q)
            IDLE: begin
                // The cycle after a done pulse is a cooldown: the requester
                // still holds its request and must not be accepted twice.
                if (!jp_wrong && !if_done_q && !lsb_done_q) begin
                    if (lsb_req) begin
                        base_n    = lsb_addr;
                        mem_a_n   = lsb_addr;
                        cnt_n     = 3'd1;
                        nbytes_n  = size_bytes(lsb_size);
                        asm_clear = TRUE;
                        if (lsb_we) begin
                            state_n    = LS_WR;
                            wdata_n    = lsb_wdata;
                            mem_dout_n = lsb_wdata[7:0];
                            mem_wr_n   = TRUE;
                        end else begin
                            state_n = LS_RD;
                        end
                    end else if (if_req) begin
                        base_n    = if_addr;
                        mem_a_n   = if_addr;
                        cnt_n     = 3'd1;
                        nbytes_n  = 3'd4;
                        asm_clear = TRUE;
                        state_n   = IF_RD;
                    end
                end
            end

            IF_RD, LS_RD: begin
                if (jp_wrong) begin
                    state_n = IDLE;
                    cnt_n   = 3'd0;
                end else begin
                    asm_capture = (cnt_q >= 3'd2);
                    if (cnt_q == nbytes_q + 3'd1) begin
                        state_n = IDLE;
                        cnt_n   = 3'd0;
                        if (state_q == IF_RD) begin
                            if_done_n = TRUE;
                            if_data_n = asm_word_next;
                        end else begin
                            lsb_done_n  = TRUE;
                            lsb_rdata_n = asm_word_next;
                        end
                    end else begin
                        cnt_n = cnt_q + 3'd1;
                        if (cnt_q < nbytes_q) begin
                            mem_a_n = base_q + ADDR_W'(cnt_q);
                        end
                    end
                end
            end

            LS_WR: begin
                if (io_stall) begin
                    mem_wr_n = mem_wr_q;
                end else if (cnt_q == nbytes_q) begin
                    state_n    = IDLE;
                    cnt_n      = 3'd0;
                    lsb_done_n = TRUE;
                end else begin
                    cnt_n      = cnt_q + 3'd1;
                    mem_a_n    = base_q + ADDR_W'(cnt_q);
                    mem_dout_n = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
                    mem_wr_n   = TRUE;
                end
            end

            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 3'd0;
            nbytes_q    <= 3'd0;
            mem_a_q     <= '0;
            mem_dout_q  <= NULL8;
            mem_wr_q    <= FALSE;
            if_done_q   <= FALSE;
            lsb_done_q  <= FALSE;
            if_data_q   <= NULL32;
            lsb_rdata_q <= NULL32;
        end else if (rdy) begin
            state_q     <= state_n;
            cnt_q       <= cnt_n;
            nbytes_q    <= nbytes_n;
            mem_a_q     <= mem_a_n;
            mem_dout_q  <= mem_dout_n;
            mem_wr_q    <= mem_wr_n;
            if_done_q   <= if_done_n;
            lsb_done_q  <= lsb_done_n;
            if_data_q   <= if_data_n;
            lsb_rdata_q <= lsb_rdata_n;
        end
    end

    always_ff @(posedge clk) begin
        if (rdy) begin
            base_q  <= base_n;
            wdata_q <= wdata_n;
        end
    end

    // While frozen in a read, present the address whose byte is still owed,
    // so mem_din already holds it on the first cycle after rdy returns.
    assign mem_a    = (!rdy && in_read) ? (base_q + ADDR_W'(cnt_q) - ADDR_W'(2)) : mem_a_q;
    assign mem_wr   = mem_wr_q & rdy & ~io_stall;
    assign mem_dout = mem_dout_q;
    assign if_done  = if_done_q;
    assign if_data  = if_data_q;
    assign lsb_done  = lsb_done_q;
    assign lsb_rdata = lsb_rdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a 4 KB byte RAM model (addresses folded to 12 bits).
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst, rdy, jp_wrong;
    logic        if_req, if_done;
    logic [31:0] if_addr, if_data;
    logic        lsb_req, lsb_we, lsb_done;
    logic [31:0] lsb_addr, lsb_wdata, lsb_rdata;
    logic [1:0]  lsb_size;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr, io_buffer_full;

    logic [7:0]  ram [0:4095];
    logic        pre_we;
    logic [11:0] pre_a;
    logic [7:0]  pre_d;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    mem_ctrl dut (
        .clk(clk), .rst(rst), .rdy(rdy), .jp_wrong(jp_wrong),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
        .lsb_req(lsb_req), .lsb_we(lsb_we), .lsb_addr(lsb_addr), .lsb_size(lsb_size),
        .lsb_wdata(lsb_wdata), .lsb_done(lsb_done), .lsb_rdata(lsb_rdata),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full)
    );

    always @(posedge clk) begin
        if (pre_we) ram[pre_a] <= pre_d;
        else if (mem_wr) ram[mem_a[11:0]] <= mem_dout;
        mem_din <= ram[mem_a[11:0]];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic poke(input logic [11:0] a, input logic [7:0] d);
        pre_a = a; pre_d = d; pre_we = 1'b1;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    task automatic run_lsb(input logic we, input logic [31:0] addr, input logic [1:0] size,
                           input logic [31:0] wd, output int dcyc,
                           output logic [31:0] a1, output logic [31:0] a2);
        dcyc = -1; a1 = '0; a2 = '0;
        lsb_req = 1'b1; lsb_we = we; lsb_addr = addr; lsb_size = size; lsb_wdata = wd;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1) a1 = mem_a;
            if (c == 2) a2 = mem_a;
            if (lsb_done) begin dcyc = c; break; end
        end
        lsb_req = 1'b0; lsb_we = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; rdy = 1'b1; jp_wrong = 1'b0; if_req = 1'b0; if_addr = '0;
        lsb_req = 1'b0; lsb_we = 1'b0; lsb_addr = '0; lsb_size = '0; lsb_wdata = '0;
        io_buffer_full = 1'b0; pre_we = 1'b0; pre_a = '0; pre_d = '0;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({if_done, lsb_done, mem_wr, mem_dout, mem_a} !== 43'd0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got %h required 0", {if_done, lsb_done, mem_wr, mem_dout, mem_a});
        end
        tests_run++;
        if ({if_data, lsb_rdata} !== 64'd0) begin
            tests_failed++;
            $display("FAIL reset_data: got %h required 0", {if_data, lsb_rdata});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_fetch();
        int dcyc = -1;
        if_req = 1'b1; if_addr = 32'h100;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c <= 4) begin
                tests_run++;
                if ({mem_wr, mem_a} !== {1'b0, 32'h100 + 32'(c) - 32'd1}) begin
                    tests_failed++;
                    $display("FAIL fetch_addr c%0d: got wr=%b a=%h required wr=0 a=%h", c, mem_wr, mem_a, 32'h100 + 32'(c) - 32'd1);
                end
            end
            if (if_done) begin dcyc = c; break; end
        end
        if_req = 1'b0;
        tests_run++;
        if (dcyc !== 6) begin tests_failed++; $display("FAIL fetch_latency: got %0d required 6", dcyc); end
        tests_run++;
        if (if_data !== 32'h00000013) begin tests_failed++; $display("FAIL fetch_data: got %h required 00000013", if_data); end
        @(negedge clk);
        tests_run++;
        if ({if_done, if_data} !== {1'b0, 32'h00000013}) begin
            tests_failed++;
            $display("FAIL fetch_pulse_hold: got done=%b data=%h required done=0 data=00000013", if_done, if_data);
        end
    endtask

    task automatic test_arbitration();
        int sdone = -1, fdone = -1;
        logic [31:0] wd = 32'hDEADBEEF;
        logic [31:0] a7 = '0;
        if_req = 1'b1; if_addr = 32'h100;
        lsb_req = 1'b1; lsb_we = 1'b1; lsb_addr = 32'h200; lsb_size = 2'd2; lsb_wdata = wd;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (c <= 4) begin
                tests_run++;
                if ({mem_wr, mem_a, mem_dout} !== {1'b1, 32'h200 + 32'(c) - 32'd1, wd[8*(c-1) +: 8]}) begin
                    tests_failed++;
                    $display("FAIL store_cycle c%0d: got wr=%b a=%h d=%h required wr=1 a=%h d=%h",
                             c, mem_wr, mem_a, mem_dout, 32'h200 + 32'(c) - 32'd1, wd[8*(c-1) +: 8]);
                end
            end
            if (c == 7) a7 = mem_a;
            if (lsb_done && sdone < 0) begin sdone = c; lsb_req = 1'b0; lsb_we = 1'b0; end
            if (if_done) begin fdone = c; break; end
        end
        if_req = 1'b0;
        tests_run++;
        if (sdone !== 5) begin tests_failed++; $display("FAIL arb_store_done: got %0d required 5", sdone); end
        tests_run++;
        if (a7 !== 32'h100) begin tests_failed++; $display("FAIL arb_fetch_start: got %h required 00000100", a7); end
        tests_run++;
        if (fdone !== 12) begin tests_failed++; $display("FAIL arb_fetch_done: got %0d required 12", fdone); end
        tests_run++;
        if ({ram[12'h203], ram[12'h202], ram[12'h201], ram[12'h200]} !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("FAIL arb_ram: got %h required deadbeef", {ram[12'h203], ram[12'h202], ram[12'h201], ram[12'h200]});
        end
        @(negedge clk);
    endtask

    task automatic test_load();
        int d; logic [31:0] a1, a2;
        run_lsb(1'b0, 32'h200, 2'd2, 32'd0, d, a1, a2);
        tests_run++;
        if ({d, lsb_rdata} !== {32'd6, 32'hDEADBEEF}) begin
            tests_failed++; $display("FAIL load_word: got cyc=%0d data=%h required cyc=6 data=deadbeef", d, lsb_rdata);
        end
        run_lsb(1'b0, 32'hFFFFFFFF, 2'd0, 32'd0, d, a1, a2);
        tests_run++;
        if ({d, a1, lsb_rdata} !== {32'd3, 32'hFFFFFFFF, 32'h000000AB}) begin
            tests_failed++; $display("FAIL load_top: got cyc=%0d a=%h data=%h required cyc=3 a=ffffffff data=000000ab", d, a1, lsb_rdata);
        end
        run_lsb(1'b0, 32'h0, 2'd0, 32'd0, d, a1, a2);
        tests_run++;
        if ({a1, lsb_rdata} !== {32'h0, 32'h0000005C}) begin
            tests_failed++; $display("FAIL load_zero: got a=%h data=%h required a=0 data=0000005c", a1, lsb_rdata);
        end
        run_lsb(1'b0, 32'hFFFFFFFF, 2'd1, 32'd0, d, a1, a2);
        tests_run++;
        if ({d, a1, a2, lsb_rdata} !== {32'd4, 32'hFFFFFFFF, 32'h0, 32'h00005CAB}) begin
            tests_failed++;
            $display("FAIL load_wrap: got cyc=%0d a1=%h a2=%h data=%h required cyc=4 a1=ffffffff a2=0 data=00005cab", d, a1, a2, lsb_rdata);
        end
    endtask

    task automatic test_flush();
        logic seen = 1'b0;
        logic [31:0] a5 = '0;
        int d; logic [31:0] a1, a2;
        lsb_req = 1'b1; lsb_we = 1'b0; lsb_addr = 32'h200; lsb_size = 2'd2;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (lsb_done) seen = 1'b1;
            if (c == 5) a5 = mem_a;
            if (c == 3) jp_wrong = 1'b1;
            if (c == 5) begin jp_wrong = 1'b0; lsb_req = 1'b0; end
        end
        tests_run++;
        if (seen !== 1'b0) begin tests_failed++; $display("FAIL flush_load_done: got 1 required 0"); end
        tests_run++;
        if (a5 !== 32'h202) begin tests_failed++; $display("FAIL flush_idle_ignore: got %h required 00000202", a5); end

        seen = 1'b0;
        lsb_req = 1'b1; lsb_addr = 32'h0; lsb_size = 2'd0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (lsb_done) seen = 1'b1;
            if (c == 2) jp_wrong = 1'b1;
            if (c == 3) begin jp_wrong = 1'b0; lsb_req = 1'b0; end
        end
        tests_run++;
        if ({seen, lsb_rdata} !== {1'b0, 32'h00005CAB}) begin
            tests_failed++; $display("FAIL flush_final_edge: got done=%b data=%h required done=0 data=00005cab", seen, lsb_rdata);
        end

        d = -1;
        lsb_req = 1'b1; lsb_we = 1'b1; lsb_addr = 32'h300; lsb_size = 2'd2; lsb_wdata = 32'h01020304;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (lsb_done) begin d = c; break; end
            if (c == 3) jp_wrong = 1'b1;
            if (c == 4) jp_wrong = 1'b0;
        end
        lsb_req = 1'b0; lsb_we = 1'b0; jp_wrong = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({d, ram[12'h303], ram[12'h302], ram[12'h301], ram[12'h300]} !== {32'd5, 32'h01020304}) begin
            tests_failed++;
            $display("FAIL flush_store: got cyc=%0d ram=%h required cyc=5 ram=01020304", d,
                     {ram[12'h303], ram[12'h302], ram[12'h301], ram[12'h300]});
        end
        run_lsb(1'b0, 32'h0, 2'd0, 32'd0, d, a1, a2);
    endtask

    task automatic test_rdy_stall();
        int dcyc = -1;
        logic wr_seen = 1'b0;
        if_req = 1'b1; if_addr = 32'h104;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c >= 3 && c <= 5 && mem_wr) wr_seen = 1'b1;
            if (if_done) begin dcyc = c; break; end
            if (c == 2) rdy = 1'b0;
            if (c == 5) rdy = 1'b1;
        end
        if_req = 1'b0; rdy = 1'b1;
        tests_run++;
        if ({dcyc, if_data} !== {32'd9, 32'h11223344}) begin
            tests_failed++; $display("FAIL rdy_fetch: got cyc=%0d data=%h required cyc=9 data=11223344", dcyc, if_data);
        end
        tests_run++;
        if (wr_seen !== 1'b0) begin tests_failed++; $display("FAIL rdy_fetch_wr: got 1 required 0"); end
        @(negedge clk);

        dcyc = -1; wr_seen = 1'b0;
        lsb_req = 1'b1; lsb_we = 1'b1; lsb_addr = 32'h500; lsb_size = 2'd0; lsb_wdata = 32'h000000C3;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (lsb_done) begin dcyc = c; break; end
            if (c == 1) begin rdy = 1'b0; #1; wr_seen = mem_wr; end
            if (c == 3) rdy = 1'b1;
        end
        lsb_req = 1'b0; lsb_we = 1'b0; rdy = 1'b1;
        tests_run++;
        if ({wr_seen, dcyc, ram[12'h500]} !== {1'b0, 32'd4, 8'hC3}) begin
            tests_failed++; $display("FAIL rdy_store: got wr=%b cyc=%0d ram=%h required wr=0 cyc=4 ram=c3", wr_seen, dcyc, ram[12'h500]);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic seen = 1'b0;
        lsb_req = 1'b1; lsb_we = 1'b1; lsb_addr = 32'h400; lsb_size = 2'd2; lsb_wdata = 32'hAABBCCDD;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        tests_run++;
        if ({mem_wr, mem_a, mem_dout, lsb_done} !== 42'd0) begin
            tests_failed++; $display("FAIL reset_mid_outputs: got %h required 0", {mem_wr, mem_a, mem_dout, lsb_done});
        end
        lsb_req = 1'b0; lsb_we = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (lsb_done) seen = 1'b1;
        end
        tests_run++;
        if ({seen, ram[12'h400], ram[12'h401]} !== {1'b0, 8'hDD, 8'h77}) begin
            tests_failed++; $display("FAIL reset_mid_ram: got done=%b ram=%h %h required done=0 ram=dd 77", seen, ram[12'h400], ram[12'h401]);
        end
    endtask

    task automatic test_io();
        int dcyc = -1;
        logic wr_stalled = 1'b0;
        logic wr_first = 1'b0;
        lsb_req = 1'b1; lsb_we = 1'b1; lsb_addr = 32'h30000; lsb_size = 2'd0; lsb_wdata = 32'h0000005A;
        io_buffer_full = 1'b1;
`ifdef MEMCTRL_IO_STALL_EN
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (lsb_done) begin dcyc = c; break; end
            if (c <= 5 && mem_wr) wr_stalled = 1'b1;
            if (c == 5) begin io_buffer_full = 1'b0; #1; wr_first = mem_wr; end
        end
        tests_run++;
        if ({wr_stalled, wr_first, dcyc} !== {1'b0, 1'b1, 32'd6}) begin
            tests_failed++; $display("FAIL io_stall: got stalled_wr=%b wr=%b cyc=%0d required 0 1 6", wr_stalled, wr_first, dcyc);
        end
`else
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1) wr_first = mem_wr;
            if (lsb_done) begin dcyc = c; break; end
        end
        tests_run++;
        if ({wr_stalled, wr_first, dcyc} !== {1'b0, 1'b1, 32'd2}) begin
            tests_failed++; $display("FAIL io_nostall: got stalled_wr=%b wr=%b cyc=%0d required 0 1 2", wr_stalled, wr_first, dcyc);
        end
`endif
        lsb_req = 1'b0; lsb_we = 1'b0; io_buffer_full = 1'b0;
        @(negedge clk);
        tests_run++;
        if (ram[12'h000] !== 8'h5A) begin tests_failed++; $display("FAIL io_ram: got %h required 5a", ram[12'h000]); end
    endtask

    initial begin
        test_reset();
        poke(12'h100, 8'h13); poke(12'h101, 8'h00); poke(12'h102, 8'h00); poke(12'h103, 8'h00);
        poke(12'h104, 8'h44); poke(12'h105, 8'h33); poke(12'h106, 8'h22); poke(12'h107, 8'h11);
        poke(12'hFFF, 8'hAB); poke(12'h000, 8'h5C); poke(12'h401, 8'h77);
        test_fetch();
        test_arbitration();
        test_load();
        test_flush();
        test_rdy_stall();
        test_reset_mid();
        test_io();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
